// File: rtl/slot_pkg.sv
// Shared types and constants for the three-reel slot controller.
package slot_pkg;
  localparam int SYM_W = 4;
  localparam logic [SYM_W-1:0] JACKPOT_SYM = 4'd7;
  localparam logic [7:0] PAY_PAIR    = 8'd2;
  localparam logic [7:0] PAY_TRIPLE  = 8'd10;
  localparam logic [7:0] PAY_JACKPOT = 8'd50;

  typedef enum logic [1:0] {
    WIN_NONE    = 2'd0,
    WIN_PAIR    = 2'd1,
    WIN_TRIPLE  = 2'd2,
    WIN_JACKPOT = 2'd3
  } win_code_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPIN   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_SCORE  = 2'd3
  } state_t;
endpackage

// File: rtl/slot_reel_ctrl_scorer.sv
// Combinational scorer: classifies a reel triple and returns its payout.
module slot_scorer
  import slot_pkg::*;
(
  input  logic [SYM_W-1:0] sym0,
  input  logic [SYM_W-1:0] sym1,
  input  logic [SYM_W-1:0] sym2,
  output win_code_t        win_code,
  output logic [7:0]       pay
);

  always_comb begin
    win_code = WIN_NONE;
    pay      = 8'd0;
    if (sym0 == sym1 && sym1 == sym2) begin
      if (sym0 == JACKPOT_SYM) begin
        win_code = WIN_JACKPOT;
        pay      = PAY_JACKPOT;
      end else begin
        win_code = WIN_TRIPLE;
        pay      = PAY_TRIPLE;
      end
    end else if (sym0 == sym1 || sym1 == sym2 || sym0 == sym2) begin
      win_code = WIN_PAIR;
      pay      = PAY_PAIR;
    end
  end

endmodule

// File: rtl/slot_reel_ctrl.sv
// Three-reel spin controller: samples the symbol stream into staggered reels,
// scores the final triple and keeps a saturating credit bank. All outputs registered.
module slot_reel_ctrl
  import slot_pkg::*;
#(
  parameter int TICK_DIV      = 5_000_000,
  parameter int SPIN_TICKS    = 20,
  parameter int STAGGER_TICKS = 10,
  parameter int START_CREDITS = 10,
  parameter int BET           = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spin,
  input  logic [SYM_W-1:0] sym_in,
  output logic [SYM_W-1:0] reel0,
  output logic [SYM_W-1:0] reel1,
  output logic [SYM_W-1:0] reel2,
  output logic             busy,
  output logic             done,
  output logic [1:0]       win_code,
  output logic [7:0]       credits,
  output logic             no_credit
);

  localparam int DW = $clog2(TICK_DIV);
  localparam int TW = $clog2(SPIN_TICKS + 2*STAGGER_TICKS + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [TW-1:0] LIVE0     = TW'(SPIN_TICKS);
  localparam logic [TW-1:0] LIVE1     = TW'(SPIN_TICKS + STAGGER_TICKS);
  localparam logic [TW-1:0] LIVE2     = TW'(SPIN_TICKS + 2*STAGGER_TICKS);
  localparam logic [TW-1:0] LAST_TCNT = TW'(SPIN_TICKS + 2*STAGGER_TICKS - 1);
  localparam logic [7:0]    BET_V     = 8'(BET);
  localparam logic [7:0]    START_V   = 8'(START_CREDITS);

  state_t           state, state_nx;
  logic [DW-1:0]    div;
  logic [TW-1:0]    tcnt;
  logic [1:0]       phase;
  logic             live1, live2;
  logic [1:0]       settle_cnt;
  logic [SYM_W-1:0] sym_clamped;
  win_code_t        score_code;
  logic [7:0]       score_pay;
  logic             accept, tick;
  logic [8:0]       credit_sum;
  logic [7:0]       credits_nx;

  assign sym_clamped = (sym_in > 4'd9) ? 4'd9 : sym_in;

  slot_scorer u_scorer (
    .sym0     (reel0),
    .sym1     (reel1),
    .sym2     (reel2),
    .win_code (score_code),
    .pay      (score_pay)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    tick       = 1'b0;
    credit_sum = {1'b0, credits} + {1'b0, score_pay};
    credits_nx = credits;
    case (state)
      ST_IDLE: begin
        if (spin && credits >= BET_V) begin
          accept     = 1'b1;
          credits_nx = credits - BET_V;
          state_nx   = ST_SPIN;
        end
      end
      ST_SPIN: begin
        tick = (div == DIV_LAST);
        if (tick && tcnt == LAST_TCNT) state_nx = ST_SETTLE;
      end
      // Three SETTLE cycles let reel1/reel2 phase samples of the last tick land.
      ST_SETTLE: begin
        if (settle_cnt == 2'd2) state_nx = ST_SCORE;
      end
      ST_SCORE: begin
        credits_nx = credit_sum[8] ? 8'hFF : credit_sum[7:0];
        state_nx   = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div        <= '0;
      tcnt       <= '0;
      phase      <= 2'd0;
      live1      <= 1'b0;
      live2      <= 1'b0;
      settle_cnt <= 2'd0;
      reel0      <= '0;
      reel1      <= '0;
      reel2      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      win_code   <= WIN_NONE;
      credits    <= START_V;
      no_credit  <= (START_V < BET_V);
    end else begin
      credits   <= credits_nx;
      no_credit <= (credits_nx < BET_V);
      done      <= (state == ST_SCORE);

      if (accept) begin
        div      <= '0;
        tcnt     <= '0;
        busy     <= 1'b1;
        win_code <= WIN_NONE;
      end else if (state == ST_SPIN) begin
        div <= tick ? '0 : div + 1'b1;
        if (tick) tcnt <= tcnt + 1'b1;
      end

      if (state == ST_SCORE) begin
        busy     <= 1'b0;
        win_code <= score_code;
      end

      settle_cnt <= (state == ST_SETTLE) ? settle_cnt + 2'd1 : 2'd0;

      // Liveness uses the pre-increment tick count; reel1/reel2 follow one and two cycles later.
      if (tick) begin
        if (tcnt < LIVE0) reel0 <= sym_clamped;
        live1 <= (tcnt < LIVE1);
        live2 <= (tcnt < LIVE2);
        phase <= 2'd1;
      end else if (phase == 2'd1) begin
        if (live1) reel1 <= sym_clamped;
        phase <= 2'd2;
      end else if (phase == 2'd2) begin
        if (live2) reel2 <= sym_clamped;
        phase <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Randomized scoreboard bench for slot_reel_ctrl with a timeline-level reference model.
module tb_slot_reel_ctrl;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int SG = 2;
  localparam int SC = 3;
  localparam int BT = 1;
  localparam int T_LAST = ST + 2*SG;
  localparam int L    = T_LAST*TD + 4;   // accept edge to done edge
  localparam int IDX0 = ST*TD - 1;       // stream index captured by reel0's last sample
  localparam int IDX1 = (ST+SG)*TD;
  localparam int IDX2 = T_LAST*TD + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       spin;
  logic [3:0] sym_in;
  logic [3:0] reel0, reel1, reel2;
  logic       busy, done;
  logic [1:0] win_code;
  logic [7:0] credits;
  logic       no_credit;

  slot_reel_ctrl #(
    .TICK_DIV(TD), .SPIN_TICKS(ST), .STAGGER_TICKS(SG), .START_CREDITS(SC), .BET(BT)
  ) dut (
    .clk(clk), .reset(reset), .spin(spin), .sym_in(sym_in),
    .reel0(reel0), .reel1(reel1), .reel2(reel2),
    .busy(busy), .done(done), .win_code(win_code),
    .credits(credits), .no_credit(no_credit)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r0, r1, r2, code, cred, nc;
  } exp_t;

  exp_t done_q[$];
  int   acc_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   model_credits;
  int   cyc = 0;
  int   acc_cyc = 0;
  bit   prev_busy = 1'b0;
  bit   prev_done = 1'b0;
  exp_t mon_e;
  int   mon_a;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int clampsym(input int v);
    return (v > 9) ? 9 : v;
  endfunction

  function automatic void score(input int a, input int b, input int c,
                                output int code, output int pay);
    if (a == b && b == c) begin
      code = (a == 7) ? 3 : 2;
      pay  = (a == 7) ? 50 : 10;
    end else if (a == b || b == c || a == c) begin
      code = 1;
      pay  = 2;
    end else begin
      code = 0;
      pay  = 0;
    end
  endfunction

  function automatic int enc(input int v);
    if (v == 9 && $urandom_range(0, 1) == 1) return int'($urandom_range(10, 15));
    return v;
  endfunction

  // Monitor: pops expectations when busy rises (accept) and when done pulses.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        prev_done = 1'b0;
      end else begin
        if (busy && !prev_busy) begin
          if (acc_q.size() == 0) check("unexpected_accept", 1, 0);
          else begin
            mon_a = acc_q.pop_front();
            check("credits_after_accept", int'(credits), mon_a);
            check("win_cleared_on_accept", int'(win_code), 0);
            acc_cyc = cyc;
          end
        end
        if (done) begin
          if (prev_done) check("done_width", 2, 1);
          else if (done_q.size() == 0) check("unexpected_done", 1, 0);
          else begin
            mon_e = done_q.pop_front();
            check("reel0", int'(reel0), mon_e.r0);
            check("reel1", int'(reel1), mon_e.r1);
            check("reel2", int'(reel2), mon_e.r2);
            check("win_code", int'(win_code), mon_e.code);
            check("credits_after_score", int'(credits), mon_e.cred);
            check("no_credit_after_score", int'(no_credit), mon_e.nc);
            check("busy_low_at_done", int'(busy), 0);
            check("done_latency", cyc - acc_cyc, L);
          end
        end
        prev_busy = busy;
        prev_done = done;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_reel0"}, int'(reel0), 0);
    check({tag, "_reel1"}, int'(reel1), 0);
    check({tag, "_reel2"}, int'(reel2), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_win"}, int'(win_code), 0);
    check({tag, "_credits"}, int'(credits), SC);
    check({tag, "_no_credit"}, int'(no_credit), (SC < BT) ? 1 : 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      spin   = 1'b0;
      sym_in = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1 check_reset_vals(tag);
    done_q.delete();
    acc_q.delete();
    model_credits = SC;
    @(negedge clk);
    spin = 1'b0;
    check_reset_vals({tag, "_held"});
    #2 reset = 1'b0;
  endtask

  // mode: 0 random, 1 jackpot, 2 non-7 triple, 3 pair, 4 all distinct
  task automatic pick(input int mode, output int a, output int b, output int c);
    int p, x, y;
    a = int'($urandom_range(0, 9)); b = int'($urandom_range(0, 9)); c = int'($urandom_range(0, 9));
    case (mode)
      1: begin a = 7; b = 7; c = 7; end
      2: begin a = int'($urandom_range(0, 8)); if (a >= 7) a++; b = a; c = a; end
      3: begin
        x = int'($urandom_range(0, 9));
        do y = int'($urandom_range(0, 9)); while (y == x);
        p = int'($urandom_range(0, 2));
        a = (p == 2) ? y : x; b = (p == 1) ? y : x; c = (p == 0) ? y : x;
      end
      4: begin
        do b = int'($urandom_range(0, 9)); while (b == a);
        do c = int'($urandom_range(0, 9)); while (c == a || c == b);
      end
      default: ;
    endcase
  endtask

  task automatic do_spin(input int mode, input bit extra, input int abort_at);
    int   syms[L];
    int   a, b, c, code, pay;
    exp_t e;
    for (int i = 0; i < L; i++) syms[i] = int'($urandom_range(0, 15));
    pick(mode, a, b, c);
    syms[IDX0] = enc(a);
    syms[IDX1] = enc(b);
    syms[IDX2] = enc(c);
    if (model_credits >= BT) begin
      model_credits -= BT;
      acc_q.push_back(model_credits);
      score(clampsym(syms[IDX0]), clampsym(syms[IDX1]), clampsym(syms[IDX2]), code, pay);
      model_credits = (model_credits + pay > 255) ? 255 : model_credits + pay;
      e.r0 = clampsym(syms[IDX0]); e.r1 = clampsym(syms[IDX1]); e.r2 = clampsym(syms[IDX2]);
      e.code = code; e.cred = model_credits; e.nc = (model_credits < BT) ? 1 : 0;
      done_q.push_back(e);
    end
    @(negedge clk);
    spin   = 1'b1;
    sym_in = 4'($urandom_range(0, 15));
    for (int k = 0; k < L; k++) begin
      @(negedge clk);
      spin   = extra && (k == 5 || k == 17 || k == L-4 || k == L-2 || k == L-1);
      sym_in = 4'(syms[k]);
      if (k == abort_at) begin
        do_reset("abort");
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : driver
    reset = 1'b1;
    spin = 1'b0;
    sym_in = 4'd0;
    model_credits = SC;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    #2 reset = 1'b0;
    idle(20);
    check_reset_vals("idle");

    do_spin(1, 1'b1, -1);   // jackpot with stray spin pulses while busy
    do_spin(4, 1'b0, -1);   // requested in the done cycle
    do_spin(3, 1'b0, -1);
    do_spin(2, 1'b1, -1);
    idle(3);
    repeat (6) begin
      do_spin(0, 1'($urandom_range(0, 1)), -1);
      idle(int'($urandom_range(0, 3)));
    end

    do_spin(0, 1'b0, 10);   // reset mid-SPIN
    idle(5);

    while (model_credits >= BT) begin
      do_spin(4, 1'b0, -1);
      idle(1);
    end
    idle(2);
    check("drained_credits", int'(credits), 0);
    check("drained_no_credit", int'(no_credit), 1);
    repeat (2) begin
      do_spin(1, 1'b0, -1);
      idle(2);
    end
    check("broke_busy", int'(busy), 0);
    check("broke_credits", int'(credits), 0);

    @(negedge clk);
    do_reset("reload");
    repeat (7) do_spin(1, 1'b0, -1);
    do_spin(2, 1'b0, -1);
    idle(5);
    check("saturated_credits", int'(credits), 255);
    check("pending_results", done_q.size(), 0);
    check("pending_accepts", acc_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
